rr_arbiter_6x64: RTL



---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick6.sv | 29 ++
 rtl/rr_arbiter_6x64.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the six-way round-robin result-path arbiter.
package arb_pkg;

    localparam int unsigned NREQ  = 6;
    localparam int unsigned SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    // Advance a requester index, wrapping 5 -> 0 so codes 6 and 7 never appear.
    function automatic sel_t next_idx(sel_t i);
        return (i >= sel_t'(NREQ - 1)) ? sel_t'(0) : i + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin pick: first valid requester after ptr, scanning with wrap.
module rr_pick6
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid_i,
    input  sel_t            ptr_i,
    output sel_t            pick_o,
    output logic            any_valid_o
);

    sel_t idx;
    logic found;

    always_comb begin
        pick_o = '0;
        idx    = ptr_i;
        found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = next_idx(idx);
            if (!found && req_valid_i[idx]) begin
                pick_o = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/rr_arbiter_6x64.sv
// Six-input round-robin arbiter with a one-entry registered output stage.
// Define ARB_LOCK_EN to add req_lock for back-to-back multi-beat grants.
module rr_arbiter_6x64
    import arb_pkg::*;
#(
    parameter int unsigned NREQ = 6,
    parameter int unsigned W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_lock,
`endif
    output logic [NREQ-1:0]   req_ready,
    output sel_t              grant_sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output sel_t              out_src,
    input  logic              out_ready
);

    if (NREQ != arb_pkg::NREQ) begin : g_nreq_check
        $error("rr_arbiter_6x64 supports exactly 6 requesters");
    end

    logic [W-1:0] req_arr [NREQ];
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
        assign req_arr[g] = req_data[g*W +: W];
    end

    sel_t         ptr_q, ptr_d, rr_pick, pick, grant_sel_q;
    logic         any_valid, can_accept, accept;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    sel_t         out_src_q, out_src_d;

    rr_pick6 u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .pick_o      (rr_pick),
        .any_valid_o (any_valid)
    );

`ifdef ARB_LOCK_EN
    logic lock_q, lock_d, lock_hold;
    sel_t lock_idx_q, lock_idx_d;

    // A held lock only binds while its owner keeps requesting.
    assign lock_hold = lock_q & req_valid[lock_idx_q];
    assign pick      = lock_hold ? lock_idx_q : rr_pick;

    always_comb begin
        lock_d     = lock_hold;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            lock_d     = req_lock[pick];
            lock_idx_d = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    assign pick = rr_pick;
`endif

    assign can_accept = !out_valid_q | out_ready;
    assign accept     = can_accept & any_valid;
    assign grant_sel  = any_valid ? pick : grant_sel_q;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (accept) begin
            ptr_d       = pick;
            out_valid_d = 1'b1;
            out_data_d  = req_arr[pick];
            out_src_d   = pick;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= sel_t'(NREQ - 1);
            grant_sel_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            grant_sel_q <= grant_sel;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
